// File: rtl/ser_tx_pkg.sv
// Shared definitions for the ser_tx serializer: FSM encoding, parameter
// legality helpers and counter sizing.
package ser_tx_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int unsigned WIDTH_MIN   = 32'd1;
    localparam int unsigned WIDTH_MAX   = 32'd32;
    localparam int unsigned CLK_DIV_MIN = 32'd2;

    function automatic bit width_ok(input int unsigned w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    function automatic bit clk_div_ok(input int unsigned d);
        return (d >= CLK_DIV_MIN) && ((d % 32'd2) == 32'd0);
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/ser_tx_clkdiv.sv
// Bit-clock divider for ser_tx: registered sclk and a wrap strobe that is
// high during the last divider count of each serial bit.
module ser_tx_clkdiv
    import ser_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_en,
    output logic o_sclk,
    output logic o_wrap
);

    localparam int unsigned   DW   = cnt_bits(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 32'd1);
    localparam logic [DW-1:0] HALF = DW'(CLK_DIV / 32'd2);

    logic [DW-1:0] r_cnt;
    logic [DW-1:0] w_cnt_nxt;
    logic          r_sclk;
    logic          r_wrap;

    // next divider count, wrapping at the end of a bit period
    always_comb begin
        w_cnt_nxt = {DW{1'b0}};
        if (r_cnt == LAST) begin
            w_cnt_nxt = {DW{1'b0}};
        end else begin
            w_cnt_nxt = r_cnt + DW'(1);
        end
    end

    // sclk and wrap are decoded from the next count so they line up with r_cnt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= {DW{1'b0}};
            r_sclk <= 1'b0;
            r_wrap <= 1'b0;
        end else if (i_en) begin
            r_cnt  <= w_cnt_nxt;
            r_sclk <= (w_cnt_nxt >= HALF);
            r_wrap <= (w_cnt_nxt == LAST);
        end else begin
            r_cnt  <= {DW{1'b0}};
            r_sclk <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign o_sclk = r_sclk;
    assign o_wrap = r_wrap;

endmodule

// File: rtl/ser_tx.sv
// Parallel-to-serial transmitter: MSB-first data with a divided bit clock
// and a frame strobe, all outputs straight from flip-flops.
module ser_tx
    import ser_tx_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tx_valid,
    input  logic [WIDTH-1:0] tx_data,
    output logic             tx_ready,
    output logic             tx_done,
    output logic             sclk,
    output logic             sdata,
    output logic             sframe
);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("ser_tx: WIDTH must be 1..32");
    end
    if (!clk_div_ok(CLK_DIV)) begin : g_bad_clk_div
        $error("ser_tx: CLK_DIV must be even and >= 2");
    end

    localparam int unsigned    BW       = cnt_bits(WIDTH);
    localparam logic [BW-1:0]  BIT_LAST = BW'(WIDTH - 32'd1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [BW-1:0]    r_bit_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_tx_ready;
    logic             r_tx_done;
    logic             r_sframe;
    logic             w_ready_nxt;
    logic             w_done_nxt;
    logic             w_sframe_nxt;
    logic             w_div_en;
    logic             w_wrap;
    logic             w_last_bit;

    assign w_div_en   = (r_state == ST_SHIFT);
    assign w_last_bit = (r_bit_cnt == BIT_LAST);

    ser_tx_clkdiv #(
        .CLK_DIV (CLK_DIV)
    ) u_clkdiv (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_div_en),
        .o_sclk  (sclk),
        .o_wrap  (w_wrap)
    );

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (tx_valid) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_wrap && w_last_bit) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // output decode, registered below so nothing reaches a port combinationally
    always_comb begin
        w_ready_nxt  = 1'b1;
        w_sframe_nxt = 1'b0;
        w_done_nxt   = 1'b0;
        if (w_state_nxt == ST_SHIFT) begin
            w_ready_nxt  = 1'b0;
            w_sframe_nxt = 1'b1;
        end else begin
            w_ready_nxt  = 1'b1;
            w_sframe_nxt = 1'b0;
        end
        if ((r_state == ST_SHIFT) && (w_state_nxt == ST_IDLE)) begin
            w_done_nxt = 1'b1;
        end else begin
            w_done_nxt = 1'b0;
        end
    end

    // shift register and bit counter; the final shift leaves zeros so sdata idles low
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shreg    <= {WIDTH{1'b0}};
            r_bit_cnt  <= {BW{1'b0}};
            r_tx_ready <= 1'b1;
            r_tx_done  <= 1'b0;
            r_sframe   <= 1'b0;
        end else begin
            r_tx_ready <= w_ready_nxt;
            r_tx_done  <= w_done_nxt;
            r_sframe   <= w_sframe_nxt;
            if ((r_state == ST_IDLE) && tx_valid) begin
                r_shreg   <= tx_data;
                r_bit_cnt <= {BW{1'b0}};
            end else if ((r_state == ST_SHIFT) && w_wrap) begin
                r_shreg   <= r_shreg << 1'b1;
                r_bit_cnt <= w_last_bit ? {BW{1'b0}} : (r_bit_cnt + BW'(1));
            end else begin
                r_shreg   <= r_shreg;
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

    assign tx_ready = r_tx_ready;
    assign tx_done  = r_tx_done;
    assign sframe   = r_sframe;
    assign sdata    = r_shreg[WIDTH-1];

endmodule

// File: tb/tb_ser_tx.sv
// Directed bench for ser_tx: an 8-bit/div-4 instance with a rising-edge
// receiver model, plus a 1-bit/div-2 instance for the minimum configuration.
module tb_ser_tx;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b1;

    logic       a_valid = 1'b0;
    logic [7:0] a_data  = 8'h00;
    logic       a_ready, a_done, a_sclk, a_sdata, a_sframe;

    logic       b_valid = 1'b0;
    logic [0:0] b_data  = 1'b0;
    logic       b_ready, b_done, b_sclk, b_sdata, b_sframe;

    int checks = 0;
    int errors = 0;

    logic [7:0] a_rx = 8'h00;
    int         a_rise_cnt = 0;
    logic       a_rise_log [64];
    int         b_rise_cnt = 0;
    logic       b_last = 1'b0;

    always #5 clk = ~clk;

    ser_tx #(.WIDTH(8), .CLK_DIV(4)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .tx_valid(a_valid), .tx_data(a_data),
        .tx_ready(a_ready), .tx_done(a_done), .sclk(a_sclk), .sdata(a_sdata), .sframe(a_sframe)
    );

    ser_tx #(.WIDTH(1), .CLK_DIV(2)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .tx_valid(b_valid), .tx_data(b_data),
        .tx_ready(b_ready), .tx_done(b_done), .sclk(b_sclk), .sdata(b_sdata), .sframe(b_sframe)
    );

    // rising-edge DFF receivers
    always @(posedge a_sclk) begin
        a_rx <= {a_rx[6:0], a_sdata};
        a_rise_log[a_rise_cnt % 64] <= a_sdata;
        a_rise_cnt <= a_rise_cnt + 1;
    end

    always @(posedge b_sclk) begin
        b_last <= b_sdata;
        b_rise_cnt <= b_rise_cnt + 1;
    end

    task automatic start_a(input logic [7:0] data, output int r0);
        @(negedge clk);
        a_data  = data;
        a_valid = 1'b1;
        @(posedge clk);
        r0 = a_rise_cnt;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        #1;
        reset_n = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL rst_ready: got %b expected 1", a_ready); end
        checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL rst_done: got %b expected 0", a_done); end
        checks++; if (a_sclk !== 1'b0)   begin errors++; $display("FAIL rst_sclk: got %b expected 0", a_sclk); end
        checks++; if (a_sdata !== 1'b0)  begin errors++; $display("FAIL rst_sdata: got %b expected 0", a_sdata); end
        checks++; if (a_sframe !== 1'b0) begin errors++; $display("FAIL rst_sframe: got %b expected 0", a_sframe); end
        checks++; if (b_ready !== 1'b1)  begin errors++; $display("FAIL rst_b_ready: got %b expected 1", b_ready); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL idle_ready: got %b expected 1", a_ready); end
        checks++; if (a_sframe !== 1'b0) begin errors++; $display("FAIL idle_sframe: got %b expected 0", a_sframe); end
    endtask

    task automatic test_single_a5;
        int r0, sf, donek, ndone;
        logic exp_sclk;
        logic [7:0] pat;
        pat = 8'hA5; sf = 0; donek = 0; ndone = 0;
        start_a(8'hA5, r0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) a_valid = 1'b0;
            if (a_sframe === 1'b1) sf++;
            if (a_done === 1'b1) begin ndone++; if (donek == 0) donek = k; end
            if (k == 1) begin
                checks++; if (a_sdata !== 1'b1) begin errors++; $display("FAIL a5_first_bit: got %b expected 1", a_sdata); end
            end
            if (k <= 32) begin
                exp_sclk = (((k - 1) % 4) >= 2);
                checks++; if (a_sclk !== exp_sclk) begin errors++; $display("FAIL a5_sclk k=%0d: got %b expected %b", k, a_sclk, exp_sclk); end
                checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL a5_ready k=%0d: got %b expected 0", k, a_ready); end
            end
        end
        checks++; if (sf != 32)    begin errors++; $display("FAIL a5_sframe_len: got %0d expected 32", sf); end
        checks++; if (donek != 33) begin errors++; $display("FAIL a5_done_time: got %0d expected 33", donek); end
        checks++; if (ndone != 1)  begin errors++; $display("FAIL a5_done_pulses: got %0d expected 1", ndone); end
        checks++; if (a_rise_cnt - r0 != 8) begin errors++; $display("FAIL a5_rises: got %0d expected 8", a_rise_cnt - r0); end
        checks++; if (a_rx !== 8'hA5) begin errors++; $display("FAIL a5_rx: got %h expected a5", a_rx); end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (a_rise_log[(r0 + i) % 64] !== pat[7 - i]) begin
                errors++; $display("FAIL a5_bit%0d: got %b expected %b", i, a_rise_log[(r0 + i) % 64], pat[7 - i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int r0, gaps;
        logic [7:0] rx1, rx2;
        logic sf [71];
        logic dn [71];
        gaps = 0; rx1 = 8'h00; rx2 = 8'h00;
        start_a(8'hA5, r0);
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 1) a_data = 8'h3C;
            if (k == 34) a_valid = 1'b0;
            sf[k] = a_sframe;
            dn[k] = a_done;
            if (k == 33) rx1 = a_rx;
            if (k == 66) rx2 = a_rx;
            if ((k >= 2) && (k <= 65) && (a_sframe !== 1'b1)) gaps++;
        end
        checks++; if (gaps != 1)      begin errors++; $display("FAIL b2b_gap: got %0d expected 1", gaps); end
        checks++; if (sf[33] !== 1'b0) begin errors++; $display("FAIL b2b_sframe33: got %b expected 0", sf[33]); end
        checks++; if (sf[34] !== 1'b1) begin errors++; $display("FAIL b2b_sframe34: got %b expected 1", sf[34]); end
        checks++; if (sf[66] !== 1'b0) begin errors++; $display("FAIL b2b_sframe66: got %b expected 0", sf[66]); end
        checks++; if (sf[70] !== 1'b0) begin errors++; $display("FAIL b2b_no_third: got %b expected 0", sf[70]); end
        checks++; if (dn[33] !== 1'b1) begin errors++; $display("FAIL b2b_done33: got %b expected 1", dn[33]); end
        checks++; if (dn[66] !== 1'b1) begin errors++; $display("FAIL b2b_done66: got %b expected 1", dn[66]); end
        checks++; if (rx1 !== 8'hA5)  begin errors++; $display("FAIL b2b_rx1: got %h expected a5", rx1); end
        checks++; if (rx2 !== 8'h3C)  begin errors++; $display("FAIL b2b_rx2: got %h expected 3c", rx2); end
        checks++; if (a_rise_cnt - r0 != 16) begin errors++; $display("FAIL b2b_rises: got %0d expected 16", a_rise_cnt - r0); end
    endtask

    task automatic test_ignore_mid;
        int r0, rdy_hi, extra;
        rdy_hi = 0; extra = 0;
        start_a(8'h0F, r0);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) a_valid = 1'b0;
            if (k == 10) begin a_valid = 1'b1; a_data = 8'hFF; end
            if (k == 11) a_valid = 1'b0;
            if ((k <= 32) && (a_ready !== 1'b0)) rdy_hi++;
            if ((k >= 34) && (a_sframe !== 1'b0)) extra++;
            if (k == 33) begin
                checks++; if (a_rx !== 8'h0F) begin errors++; $display("FAIL ign_rx: got %h expected 0f", a_rx); end
                checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL ign_done: got %b expected 1", a_done); end
            end
        end
        checks++; if (rdy_hi != 0) begin errors++; $display("FAIL ign_ready: got %0d high cycles expected 0", rdy_hi); end
        checks++; if (extra != 0)  begin errors++; $display("FAIL ign_queued: got %0d frame cycles expected 0", extra); end
        checks++; if (a_rise_cnt - r0 != 8) begin errors++; $display("FAIL ign_rises: got %0d expected 8", a_rise_cnt - r0); end
    endtask

    task automatic test_data_change;
        int r0;
        start_a(8'h81, r0);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            if (k == 1) begin a_data = 8'h7E; a_valid = 1'b0; end
        end
        checks++; if (a_rx !== 8'h81)  begin errors++; $display("FAIL chg_rx: got %h expected 81", a_rx); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL chg_done: got %b expected 1", a_done); end
    endtask

    task automatic test_reset_mid;
        int r0;
        bit found;
        found = 1'b0;
        start_a(8'hF0, r0);
        @(negedge clk);
        a_valid = 1'b0;
        for (int n = 0; (n < 100) && !found; n++) begin
            @(posedge clk);
            #1;
            if (a_rise_cnt - r0 == 4) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_timeout: got %0d rises expected 4", a_rise_cnt - r0); end
        reset_n = 1'b0;
        #1;
        checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL rmid_ready: got %b expected 1", a_ready); end
        checks++; if (a_sframe !== 1'b0) begin errors++; $display("FAIL rmid_sframe: got %b expected 0", a_sframe); end
        checks++; if (a_sclk !== 1'b0)   begin errors++; $display("FAIL rmid_sclk: got %b expected 0", a_sclk); end
        checks++; if (a_sdata !== 1'b0)  begin errors++; $display("FAIL rmid_sdata: got %b expected 0", a_sdata); end
        checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL rmid_done: got %b expected 0", a_done); end
        a_data  = 8'h55;
        a_valid = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        r0 = a_rise_cnt;
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_sframe !== 1'b1) begin errors++; $display("FAIL rmid_accept: got %b expected 1", a_sframe); end
        repeat (32) @(negedge clk);
        checks++; if (a_done !== 1'b1)  begin errors++; $display("FAIL rmid_new_done: got %b expected 1", a_done); end
        checks++; if (a_rx !== 8'h55)   begin errors++; $display("FAIL rmid_rx: got %h expected 55", a_rx); end
        checks++; if (a_rise_cnt - r0 != 8) begin errors++; $display("FAIL rmid_rises: got %0d expected 8", a_rise_cnt - r0); end
    endtask

    task automatic test_div2_w1;
        int br0;
        logic [3:0] e_sf, e_sclk, e_sd, e_dn, e_rdy;
        e_sf = 4'b0011; e_sclk = 4'b0010; e_sd = 4'b0011; e_dn = 4'b0100; e_rdy = 4'b1100;
        @(negedge clk);
        b_data  = 1'b1;
        b_valid = 1'b1;
        @(posedge clk);
        br0 = b_rise_cnt;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (k == 1) b_valid = 1'b0;
            checks++; if (b_sframe !== e_sf[k-1])  begin errors++; $display("FAIL w1_sframe k=%0d: got %b expected %b", k, b_sframe, e_sf[k-1]); end
            checks++; if (b_sclk !== e_sclk[k-1])  begin errors++; $display("FAIL w1_sclk k=%0d: got %b expected %b", k, b_sclk, e_sclk[k-1]); end
            checks++; if (b_sdata !== e_sd[k-1])   begin errors++; $display("FAIL w1_sdata k=%0d: got %b expected %b", k, b_sdata, e_sd[k-1]); end
            checks++; if (b_done !== e_dn[k-1])    begin errors++; $display("FAIL w1_done k=%0d: got %b expected %b", k, b_done, e_dn[k-1]); end
            checks++; if (b_ready !== e_rdy[k-1])  begin errors++; $display("FAIL w1_ready k=%0d: got %b expected %b", k, b_ready, e_rdy[k-1]); end
        end
        checks++; if (b_rise_cnt - br0 != 1) begin errors++; $display("FAIL w1_rises: got %0d expected 1", b_rise_cnt - br0); end
        checks++; if (b_last !== 1'b1)       begin errors++; $display("FAIL w1_rx: got %b expected 1", b_last); end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_ignore_mid();
        test_data_change();
        test_reset_mid();
        test_div2_w1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ser_tx.md
SER_TX -- requirements
Module: ser_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 8: word length in bits; legal range 1..32.
REQ-002 SHALL have parameter CLK_DIV, default 4: clk cycles per serial bit; must be even and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tx_valid, input, 1 bit: a word is offered on tx_data.
REQ-006 SHALL have port tx_data, input, WIDTH bits: parallel word to transmit.
REQ-007 SHALL have port tx_ready, output, 1 bit: the block can accept a word this cycle.
REQ-008 SHALL have port tx_done, output, 1 bit: one-cycle pulse marking the end of a frame.
REQ-009 SHALL have port sclk, output, 1 bit: serial bit clock for a rising-edge D-flip-flop receiver.
REQ-010 SHALL have port sdata, output, 1 bit: serial data, MSB first.
REQ-011 SHALL have port sframe, output, 1 bit: high while a word is being shifted.

Function
REQ-012 SHALL implement a two-state machine: IDLE and SHIFT.
REQ-013 SHALL, in IDLE, hold tx_ready=1, sframe=0, sclk=0 and sdata=0.
REQ-014 SHALL accept a word on the clk edge where tx_valid=1 and tx_ready=1; that edge is E0.
REQ-015 SHALL capture tx_data at E0; later tx_data changes do not affect the frame in flight.
REQ-016 SHALL, at E0, enter SHIFT with bit counter=0, divider counter=0 and sdata=tx_data[WIDTH-1]; after E0, tx_ready=0 and sframe=1.
REQ-017 SHALL, in SHIFT, increment the divider counter every clk cycle, wrapping from CLK_DIV-1 to 0.
REQ-018 SHALL drive sclk=0 for divider counter values 0..CLK_DIV/2-1 and sclk=1 for values CLK_DIV/2..CLK_DIV-1.
REQ-019 SHALL change sdata only on divider wrap, which is an sclk falling or idle-low point, so sdata is stable for CLK_DIV/2 cycles before and through each sclk rising edge.
REQ-020 SHALL, on wrap when bit counter < WIDTH-1, shift to the next lower bit and increment the bit counter.
REQ-021 SHALL, on wrap when bit counter = WIDTH-1, return to IDLE with tx_ready=1, sframe=0, sclk=0, sdata=0, and pulse tx_done=1 for exactly that first IDLE cycle.
REQ-022 SHALL keep sframe high for exactly WIDTH*CLK_DIV clk cycles per frame, with exactly WIDTH sclk rising edges.
REQ-023 SHALL allow back-to-back frames: acceptance on the tx_done cycle gives exactly one clk cycle with sframe=0 between frames.
REQ-024 SHALL ignore tx_valid while in SHIFT; no queuing and no loss of the frame in flight.
REQ-025 SHALL drive every output directly from a flip-flop, with no combinational path from inputs to outputs, so sclk is glitch-free.

Reset
REQ-026 SHALL, while reset_n=0, force IDLE asynchronously: tx_ready=1, tx_done=0, sclk=0, sdata=0, sframe=0, and all counters and the shift register cleared.
REQ-027 SHALL abandon a frame interrupted by reset with no resumption; the first edge after reset_n rises may accept a new word.

Structure
REQ-028 SHALL place the state encodings (IDLE=0, SHIFT=1) and the parameter legality checks in shared package ser_tx_pkg.
REQ-029 SHALL use one sub-module, ser_tx_clkdiv, holding the divider counter; it outputs registered sclk and a one-cycle wrap strobe, and is enabled only in SHIFT.

Verification
REQ-030 SHALL check: WIDTH=8, CLK_DIV=4, send 8'hA5 -> sdata at the 8 sclk rising edges = 1,0,1,0,0,1,0,1; a rising-edge DFF shift register captures 8'hA5; sframe high 32 cycles; tx_done at E0+33.
REQ-031 SHALL check: back-to-back 8'hA5 then 8'h3C, tx_valid held -> second E0 on the tx_done cycle; one-cycle sframe gap; receiver gets A5 then 3C.
REQ-032 SHALL check: tx_valid pulsed with 8'hFF mid-frame of 8'h0F -> received 8'h0F only; tx_ready stays 0.
REQ-033 SHALL check: tx_data changed from 8'h81 to 8'h7E one cycle after E0 -> received 8'h81.
REQ-034 SHALL check: reset_n low at the fourth sclk rise of a frame -> all outputs idle immediately without waiting for clk; a new 8'h55 after release is received intact.
REQ-035 SHALL check: CLK_DIV=2, WIDTH=1, send 1'b1 -> sframe high 2 cycles, sclk high in the second, sdata=1, tx_done at E0+3.
